// File: rtl/reorder_queue_drain_pkg.sv
// reorder_queue_drain_pkg: derivations, drain FSM encoding and RAM row addressing shared by both sides of the reorder queue.
package reorder_queue_drain_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_CLEAR} state_t;
  localparam int DW_BITS = 32;
  function automatic int pci_words(input int width);
    return width / DW_BITS;
  endfunction
  function automatic int num_tags(input int tag_width);
    return 1 << tag_width;
  endfunction
  function automatic int row_addr(input int tag, input int row, input int stride);
    return (tag << stride) + row;
  endfunction
endpackage

// File: rtl/reorder_drain_skid.sv
// reorder_drain_skid: 2-entry ready/valid FIFO; the head entry is presented directly and stays put until popped.
module reorder_drain_skid #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [P-1:0] din_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [P-1:0] dout_o,
  output logic [1:0]   cnt_o
);
  logic [P-1:0] mem_q [2];
  logic         wp_q, rp_q, pop;
  logic [1:0]   cnt_q;
  assign valid_o = cnt_q != 2'd0;
  assign pop     = valid_o & ready_i;
  assign dout_o  = mem_q[rp_q];
  assign cnt_o   = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) mem_q[wp_q] <= din_i;
      wp_q  <= wp_q ^ push_i;
      rp_q  <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop);
    end
  end
endmodule

// File: rtl/reorder_queue_drain.sv
// reorder_queue_drain: releases finished tags strictly in issue order, streaming their RAM payload and clearing each tag once drained.
module reorder_queue_drain
  import reorder_queue_drain_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH         = 128,
  parameter int C_TAG_WIDTH              = 5,
  parameter int C_TAG_DW_COUNT_WIDTH     = 8,
  parameter int C_DATA_ADDR_STRIDE_WIDTH = 5,
  parameter int C_DATA_ADDR_WIDTH        = 10
) (
  input  logic                                                   CLK,
  input  logic                                                   RST,
  input  logic [(1<<C_TAG_WIDTH)-1:0]                            TAG_FINISH,
  input  logic                                                   PKT_VALID,
  input  logic [C_TAG_WIDTH-1:0]                                 PKT_TAG,
  input  logic [C_TAG_DW_COUNT_WIDTH-1:0]                        PKT_WORDS,
  input  logic                                                   PKT_ERR,
  output logic [(1<<C_TAG_WIDTH)-1:0]                            TAG_CLEAR,
  output logic [C_DATA_ADDR_WIDTH*(C_PCI_DATA_WIDTH/32)-1:0]     RAM_ADDR,
  input  logic [C_PCI_DATA_WIDTH-1:0]                            RAM_DATA,
  output logic                                                   ENG_VALID,
  input  logic                                                   ENG_READY,
  output logic [C_PCI_DATA_WIDTH-1:0]                            ENG_DATA,
  output logic [$clog2(C_PCI_DATA_WIDTH/32+1)-1:0]               ENG_DATA_COUNT,
  output logic [C_TAG_WIDTH-1:0]                                 ENG_TAG,
  output logic                                                   ENG_DONE,
  output logic                                                   ENG_ERR
);
  localparam int W  = pci_words(C_PCI_DATA_WIDTH);
  localparam int NT = num_tags(C_TAG_WIDTH);
  localparam int CW = $clog2(W + 1);
  localparam int PW = C_PCI_DATA_WIDTH + CW + C_TAG_WIDTH + 2;
  state_t                              state_q;
  logic [C_TAG_WIDTH-1:0]              head_q, infl_tag_q;
  logic [C_TAG_DW_COUNT_WIDTH-1:0]     remain_q, remain_d, head_words;
  logic [C_TAG_DW_COUNT_WIDTH-1:0]     words_q [NT];
  logic [C_DATA_ADDR_STRIDE_WIDTH-1:0] row_q;
  logic [C_DATA_ADDR_WIDTH-1:0]        addr_q;
  logic [NT-1:0]                       pending_q, errtab_q, tag_clear_q, clr_mask, err_set;
  logic [CW-1:0]                       beat_cnt, infl_cnt_q;
  logic                                err_q, infl_q, infl_done_q, infl_err_q;
  logic                                head_pkt, head_err, head_ready, pop, room, issue, drained;
  logic [2:0]                          occ;
  logic [1:0]                          fifo_cnt;
  logic [C_PCI_DATA_WIDTH-1:0]         data_masked;
  logic [PW-1:0]                       fifo_in, fifo_out;
  // Same-cycle write-side updates for the head tag are forwarded so the load never sees stale table entries.
  always_comb begin
    head_pkt   = PKT_VALID && PKT_TAG == head_q;
    head_words = head_pkt ? PKT_WORDS : words_q[head_q];
    head_err   = errtab_q[head_q] | (head_pkt & PKT_ERR);
    head_ready = pending_q[head_q] | TAG_FINISH[head_q];
    pop        = ENG_VALID & ENG_READY;
    occ        = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);
    room       = occ < 3'd2;
    beat_cnt   = remain_q >= C_TAG_DW_COUNT_WIDTH'(W) ? CW'(W) : CW'(remain_q);
    remain_d   = remain_q - C_TAG_DW_COUNT_WIDTH'(beat_cnt);
    issue      = state_q == S_READ && room;
    drained    = state_q == S_CLEAR && pop && ENG_DONE;
    clr_mask   = drained ? NT'(1) << head_q : '0;
    err_set    = PKT_VALID && PKT_ERR ? NT'(1) << PKT_TAG : '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      remain_q    <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      pending_q   <= '0;
      errtab_q    <= '0;
      tag_clear_q <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_cnt_q  <= '0;
      infl_tag_q  <= '0;
      infl_done_q <= 1'b0;
      infl_err_q  <= 1'b0;
      for (int t = 0; t < NT; t++) words_q[t] <= '0;
    end else begin
      tag_clear_q <= clr_mask;
      pending_q   <= (pending_q & ~clr_mask) | TAG_FINISH;
      errtab_q    <= (errtab_q & ~clr_mask) | err_set;
      if (PKT_VALID) words_q[PKT_TAG] <= PKT_WORDS;
      infl_q <= issue;
      if (issue) begin
        addr_q      <= C_DATA_ADDR_WIDTH'(row_addr(int'(head_q), int'(row_q), C_DATA_ADDR_STRIDE_WIDTH));
        infl_cnt_q  <= beat_cnt;
        infl_tag_q  <= head_q;
        infl_done_q <= remain_d == '0;
        infl_err_q  <= err_q;
        remain_q    <= remain_d;
        row_q       <= row_q + C_DATA_ADDR_STRIDE_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: if (head_ready) begin
          remain_q <= head_words;
          row_q    <= '0;
          err_q    <= head_err;
          state_q  <= S_READ;
        end
        S_READ: if (issue && remain_d == '0) state_q <= S_CLEAR;
        S_CLEAR: if (drained) begin
          head_q  <= head_q + C_TAG_WIDTH'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // DWs beyond the beat count are zeroed so the stream never carries another tag's leftovers.
  for (genvar g = 0; g < W; g++) begin : g_mask
    assign data_masked[32*g+:32] = CW'(g) < infl_cnt_q ? RAM_DATA[32*g+:32] : 32'd0;
  end
  assign fifo_in   = {data_masked, infl_cnt_q, infl_tag_q, infl_done_q, infl_err_q};
  assign {ENG_DATA, ENG_DATA_COUNT, ENG_TAG, ENG_DONE, ENG_ERR} = fifo_out;
  assign RAM_ADDR  = {W{addr_q}};
  assign TAG_CLEAR = tag_clear_q;
  reorder_drain_skid #(.P(PW)) u_skid (
    .clk    (CLK),
    .rst    (RST),
    .push_i (infl_q),
    .din_i  (fifo_in),
    .ready_i(ENG_READY),
    .valid_o(ENG_VALID),
    .dout_o (fifo_out),
    .cnt_o  (fifo_cnt)
  );
endmodule

// File: tb/tb_reorder_queue_drain.sv
// tb_reorder_queue_drain: directed stimulus with an in-order tag release model and a per-cycle output monitor.
module tb_reorder_queue_drain;
  typedef struct packed {
    logic [127:0] data;
    logic [2:0]   cnt;
    logic [4:0]   tag;
    logic         done;
    logic         err;
  } beat_t;
  logic         CLK, RST, PKT_VALID, PKT_ERR, ENG_VALID, ENG_READY, ENG_DONE, ENG_ERR;
  logic [31:0]  TAG_FINISH, TAG_CLEAR;
  logic [4:0]   PKT_TAG, ENG_TAG;
  logic [7:0]   PKT_WORDS;
  logic [39:0]  RAM_ADDR;
  logic [127:0] RAM_DATA, ENG_DATA;
  logic [2:0]   ENG_DATA_COUNT;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  m_words [32];
  logic [31:0] m_pend, m_err;
  int          m_head;
  beat_t       exp_q[$], log_q[$], e, cur, held;
  logic [31:0] clr_q[$], clr_log[$];
  bit          hold;
  int          b0, c0;
  reorder_queue_drain dut (
    .CLK(CLK), .RST(RST), .TAG_FINISH(TAG_FINISH), .PKT_VALID(PKT_VALID), .PKT_TAG(PKT_TAG),
    .PKT_WORDS(PKT_WORDS), .PKT_ERR(PKT_ERR), .TAG_CLEAR(TAG_CLEAR), .RAM_ADDR(RAM_ADDR),
    .RAM_DATA(RAM_DATA), .ENG_VALID(ENG_VALID), .ENG_READY(ENG_READY), .ENG_DATA(ENG_DATA),
    .ENG_DATA_COUNT(ENG_DATA_COUNT), .ENG_TAG(ENG_TAG), .ENG_DONE(ENG_DONE), .ENG_ERR(ENG_ERR)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] f(input int bank, input int addr);
    return {8'hA5, 4'(bank), 10'(addr), 10'(addr) ^ 10'h2AA};
  endfunction
  always_comb begin
    RAM_DATA = '0;
    for (int i = 0; i < 4; i++) RAM_DATA[32*i+:32] = f(i, int'(RAM_ADDR[10*i+:10]));
  end
  function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  // Expected beats for a tag: ceil(words/4) beats (at least one), word k from bank k%4 at row k/4.
  function automatic void gen_beats(input int t);
    int n, nb, c;
    beat_t x;
    n  = int'(m_words[t]);
    nb = n == 0 ? 1 : (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      c = n - 4 * b < 4 ? n - 4 * b : 4;
      x = '0;
      for (int j = 0; j < c; j++) x.data[32*j+:32] = f(j, (t << 5) + b);
      x.cnt  = 3'(c);
      x.tag  = 5'(t);
      x.done = b == nb - 1;
      x.err  = m_err[t];
      exp_q.push_back(x);
    end
  endfunction
  always @(negedge CLK) begin
    cur = '{ENG_DATA, ENG_DATA_COUNT, ENG_TAG, ENG_DONE, ENG_ERR};
    if (RST) begin
      for (int t = 0; t < 32; t++) m_words[t] = '0;
      m_pend = '0;
      m_err  = '0;
      m_head = 0;
      exp_q.delete();
      clr_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 160'(ENG_VALID), 160'(1));
        chk("stall_hold", 160'(cur), 160'(held));
      end
      hold = ENG_VALID && !ENG_READY;
      held = cur;
      if (ENG_VALID && ENG_READY) begin
        log_q.push_back(cur);
        if (exp_q.size() == 0 && m_pend[m_head]) gen_beats(m_head);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got tag %0d count %0d, required no beat", ENG_TAG, ENG_DATA_COUNT);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 160'(cur.data), 160'(e.data));
          chk("beat_count", 160'(cur.cnt), 160'(e.cnt));
          chk("beat_tag", 160'(cur.tag), 160'(e.tag));
          chk("beat_done", 160'(cur.done), 160'(e.done));
          chk("beat_err", 160'(cur.err), 160'(e.err));
          if (e.done) begin
            clr_q.push_back(32'd1 << m_head);
            m_pend[m_head] = 1'b0;
            m_err[m_head]  = 1'b0;
            m_head = (m_head + 1) % 32;
          end
        end
      end
      if (TAG_CLEAR != '0) begin
        clr_log.push_back(TAG_CLEAR);
        if (clr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_clear: got %0h, required 0", TAG_CLEAR);
        end else chk("tag_clear", 160'(TAG_CLEAR), 160'(clr_q.pop_front()));
      end
      if (PKT_VALID) begin
        m_words[PKT_TAG] = PKT_WORDS;
        if (PKT_ERR) m_err[PKT_TAG] = 1'b1;
      end
      m_pend = m_pend | TAG_FINISH;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic pkt(input int t, input int w, input bit er);
    PKT_VALID = 1'b1;
    PKT_TAG   = 5'(t);
    PKT_WORDS = 8'(w);
    PKT_ERR   = er;
    tick(1);
    PKT_VALID = 1'b0;
    PKT_ERR   = 1'b0;
  endtask
  task automatic fin(input logic [31:0] m);
    TAG_FINISH = m;
    tick(1);
    TAG_FINISH = '0;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask
  task automatic wait_idle(input int budget, input bit tog);
    int c = 0;
    while (!(m_pend == '0 && exp_q.size() == 0 && clr_q.size() == 0) && c < budget) begin
      tick(1);
      if (tog) ENG_READY = ~ENG_READY;
      c++;
    end
    ENG_READY = 1'b1;
    chk("drain_timeout", 160'(c >= budget), 160'(0));
    tick(3);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    RST = 1'b1;
    TAG_FINISH = '0;
    PKT_VALID = 1'b0;
    PKT_TAG = '0;
    PKT_WORDS = '0;
    PKT_ERR = 1'b0;
    ENG_READY = 1'b1;
    tick(2);
    chk("rst_valid", 160'(ENG_VALID), 160'(0));
    chk("rst_clear", 160'(TAG_CLEAR), 160'(0));
    chk("rst_addr", 160'(RAM_ADDR), 160'(0));
    chk("rst_data", 160'(ENG_DATA), 160'(0));
    RST = 1'b0;
    tick(1);
    // 10 words over 4 banks, plus first-beat latency
    b0 = log_q.size();
    c0 = clr_log.size();
    pkt(0, 10, 1'b0);
    fin(32'h1);
    chk("lat_n0", 160'(ENG_VALID), 160'(0));
    tick(1);
    chk("lat_n1", 160'(ENG_VALID), 160'(0));
    tick(1);
    chk("lat_n2", 160'(ENG_VALID), 160'(1));
    wait_idle(100, 1'b0);
    chk("t1_nbeats", 160'(log_q.size() - b0), 160'(3));
    chk("t1_cnt0", 160'(log_q[b0].cnt), 160'(4));
    chk("t1_cnt1", 160'(log_q[b0+1].cnt), 160'(4));
    chk("t1_cnt2", 160'(log_q[b0+2].cnt), 160'(2));
    chk("t1_done", 160'({log_q[b0].done, log_q[b0+1].done, log_q[b0+2].done}), 160'(3'b001));
    chk("t1_dw0_row0", 160'(log_q[b0].data[31:0]), 160'(32'hA50002AA));
    chk("t1_dw0_row2", 160'(log_q[b0+2].data[31:0]), 160'(32'hA5000AA8));
    chk("t1_nclear", 160'(clr_log.size() - c0), 160'(1));
    chk("t1_clear", 160'(clr_log[c0]), 160'(32'h1));
    // reset while the second of four beats is presented
    pkt(0, 16, 1'b0);
    fin(32'h1);
    b0 = log_q.size();
    for (int c = 0; c < 50 && log_q.size() < b0 + 1; c++) tick(1);
    c0 = clr_log.size();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_valid", 160'(ENG_VALID), 160'(0));
    chk("mid_rst_data", 160'(ENG_DATA), 160'(0));
    chk("mid_rst_count", 160'(ENG_DATA_COUNT), 160'(0));
    chk("mid_rst_clear", 160'(TAG_CLEAR), 160'(0));
    tick(2);
    RST = 1'b0;
    tick(2);
    b0 = log_q.size();
    pkt(0, 16, 1'b0);
    fin(32'h1);
    wait_idle(100, 1'b0);
    chk("rst_no_clear", 160'(clr_log.size() - c0), 160'(1));
    chk("rst_nbeats", 160'(log_q.size() - b0), 160'(4));
    chk("rst_first_tag", 160'(log_q[b0].tag), 160'(0));
    chk("rst_first_row0", 160'(log_q[b0].data[31:0]), 160'(32'hA50002AA));
    // out-of-order finishes are released in tag order
    do_reset();
    b0 = log_q.size();
    c0 = clr_log.size();
    pkt(0, 4, 1'b1);
    pkt(1, 5, 1'b0);
    pkt(2, 3, 1'b0);
    fin(32'h4);
    fin(32'h2);
    tick(6);
    chk("ooo_no_output", 160'(ENG_VALID), 160'(0));
    fin(32'h1);
    wait_idle(100, 1'b0);
    chk("ooo_tags", 160'({log_q[b0].tag, log_q[b0+1].tag, log_q[b0+2].tag, log_q[b0+3].tag}), 160'({5'd0, 5'd1, 5'd1, 5'd2}));
    chk("ooo_err0", 160'(log_q[b0].err), 160'(1));
    chk("ooo_clears", 160'({clr_log[c0], clr_log[c0+1], clr_log[c0+2]}), 160'({32'h1, 32'h2, 32'h4}));
    // 8-beat tag with alternating ready
    b0 = log_q.size();
    pkt(3, 32, 1'b0);
    fin(32'h8);
    wait_idle(200, 1'b1);
    chk("stall_nbeats", 160'(log_q.size() - b0), 160'(8));
    // one-word tag, then an errored zero-word tag
    pkt(4, 1, 1'b0);
    pkt(5, 0, 1'b1);
    fin(32'h30);
    wait_idle(100, 1'b0);
    chk("zero_cnt", 160'(log_q[log_q.size()-1].cnt), 160'(0));
    chk("zero_tag", 160'(log_q[log_q.size()-1].tag), 160'(5));
    chk("zero_done_err", 160'({log_q[log_q.size()-1].done, log_q[log_q.size()-1].err}), 160'(2'b11));
    chk("zero_clear", 160'(clr_log[clr_log.size()-1]), 160'(32'h20));
    // run the head through the remaining tags so it wraps
    for (int t = 6; t < 32; t++) pkt(t, t % 7, t == 31);
    fin(32'hFFFFFFC0);
    wait_idle(1500, 1'b0);
    chk("wrap_clear31", 160'(clr_log[clr_log.size()-1]), 160'(32'h80000000));
    pkt(0, 3, 1'b0);
    fin(32'h1);
    wait_idle(100, 1'b0);
    chk("reuse_tag", 160'(log_q[log_q.size()-1].tag), 160'(0));
    chk("reuse_cnt", 160'(log_q[log_q.size()-1].cnt), 160'(3));
    chk("reuse_err", 160'(log_q[log_q.size()-1].err), 160'(0));
    chk("reuse_done", 160'(log_q[log_q.size()-1].done), 160'(1));
    chk("reuse_data", 160'(log_q[log_q.size()-1].data), 160'(128'h00000000_A52002AA_A51002AA_A50002AA));
    chk("reuse_clear", 160'(clr_log[clr_log.size()-1]), 160'(32'h1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
